// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder: accepts one request at a time,
// stalls the CPU while busy and completes with a one-cycle ack carrying read data and a fault flag.
module mem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            fault_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     mem_q [DEPTH];
  logic            finish_d;
  logic            wr_en_d;

  // Misaligned or beyond the last storage word.
  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= LIMIT);
  endfunction

  // Completion strobe, storage write enable and the combinational stall.
  always_comb begin
    finish_d = (state_q == BUSY) && (cnt_q == 4'd0);
    wr_en_d  = finish_d && we_q && !fault_q;
    stall_o  = ((state_q == IDLE) && req_i) || (state_q == BUSY);
  end

  // Request FSM with registered ack/err/rdata.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            fault_q <= addr_fault(addr_i);
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
            err_q   <= fault_q;
            // rdata_o only moves on read completion, faulted reads return zero.
            if (!we_q) begin
              rdata_q <= fault_q ? 32'd0 : mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array, cleared by reset and written on the edge entering DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (wr_en_d) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit storage words (power of two, 2..256).
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request acceptance to ack (1..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_i  input  1  requester asserts for a memory access; held high with operands stable until ack_o.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-007 SHALL have port addr_i  input  32  byte address; sampled at acceptance.
REQ-008 SHALL have port wdata_i  input  32  write data; sampled at acceptance.
REQ-009 SHALL have port stall_o  output  1  pipeline-freeze request to the CPU hazard logic.
REQ-010 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata_o  output  32  read data, valid when ack_o=1 for a read.
REQ-012 SHALL have port err_o  output  1  access fault flag, valid when ack_o=1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: if req_i=1, SHALL capture we_i/addr_i/wdata_i, load counter with LATENCY-1, go BUSY; else stay IDLE.
REQ-015 BUSY: counter==0 -> go DONE; else decrement counter, stay BUSY.
REQ-016 DONE: SHALL return to IDLE unconditionally; req_i in DONE ignored (next acceptance earliest one cycle after DONE).
REQ-017 Acceptance at edge T SHALL yield ack_o=1 exactly in the cycle following edge T+LATENCY, for one cycle.
REQ-018 stall_o SHALL be combinational: 1 when (IDLE and req_i=1) or BUSY; 0 in DONE and in IDLE with req_i=0.
REQ-019 Word index SHALL be captured addr[log2(DEPTH)+1:2].
REQ-020 Fault SHALL be captured addr[1:0]!=0 or captured addr >= 4*DEPTH.
REQ-021 Valid write SHALL update storage on the edge entering DONE; faulted write SHALL leave storage unchanged.
REQ-022 Valid read SHALL load rdata_o from storage on the edge entering DONE; faulted read SHALL load rdata_o=0.
REQ-023 rdata_o SHALL hold its value until the next read completion; writes SHALL not change rdata_o.
REQ-024 err_o SHALL be registered on the edge entering DONE, valid only with ack_o, cleared on leaving DONE.
REQ-025 Read of a word written by the immediately preceding write SHALL return the new data.
REQ-026 Counter width SHALL be 4 bits; no wrap occurs within legal LATENCY.

Reset
REQ-027 rst_i=1 SHALL immediately force state IDLE, counter 0, ack_o 0, err_o 0, rdata_o 0, all storage words 0.
REQ-028 Reset in BUSY SHALL abort the access: no storage update, no ack_o after release.
REQ-029 After rst_i falls, a request SHALL be acceptable at the first rising edge.

Verification (DEPTH=32, LATENCY=3)
REQ-030 Write 0xDEADBEEF to 0x10 accepted at edge 0 -> stall_o high cycles 0-2, ack_o=1 cycle 3 only, err_o=0; later read 0x10 returns 0xDEADBEEF.
REQ-031 Back-to-back: write 0x1234 @0x04 then read @0x04 issued first IDLE cycle after ack -> rdata_o=0x00001234 with ack, 4-cycle spacing between ack pulses minimum.
REQ-032 Read 0x02 (misaligned) and read 0x80 (out of range) -> ack_o with err_o=1, rdata_o=0; write 0x80 leaves all words unchanged.
REQ-033 Assert rst_i during BUSY of write 0xAAAA @0x08 -> outputs zero immediately, no ack, read 0x08 afterwards returns 0.
REQ-034 req_i held low -> stall_o=0, ack_o=0 indefinitely; req_i high in DONE cycle -> not accepted until next cycle.
REQ-035 LATENCY=1 build: accept edge 0 -> ack_o in cycle 1, stall_o high cycle 0 only.
